// File: rtl/pong_game_engine_pkg.sv
// pong_game_engine_pkg
// Shared game constants, the game-state encoding and small position helpers.
// The display stage imports the same package so sprite sizes stay in step
// with the engine.
package pong_game_engine_pkg;

    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_W     = 10;
    localparam int DEF_PADDLE_H     = 40;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_PADDLE_SPEED = 4;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_MAX_MISSES   = 3;
    localparam int DEF_BALL_X0      = 316;
    localparam int DEF_BALL_Y0      = 236;
    localparam int DEF_PADDLE_Y0    = 220;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    // One extra bit over the 10-bit pixel range so subtraction below zero
    // and addition past the screen edge never wrap.
    typedef logic signed [10:0] pos_t;

    function automatic pos_t to_pos(input logic [9:0] v);
        return $signed({1'b0, v});
    endfunction

    // Negative results clamp to 0; the positive range always fits 10 bits.
    function automatic logic [9:0] to_pix(input pos_t v);
        if (v[10])
            return '0;
        return v[9:0];
    endfunction

endpackage

// File: rtl/pong_game_engine_if.sv
// pong_game_engine_if
// Bundles the engine's timing/button inputs and its rendered game outputs.
//   sx, sy                         : current pixel from the timing generator
//   btn_up, btn_down, btn_start    : synchronised button levels
//   paddle0_pos_y, ball_pos_x/y    : sprite positions for the display stage
//   score, miss_count, game_state  : game status
// master = stimulus/timing side, slave = engine side.
interface pong_game_engine_if;
    import pong_game_engine_pkg::*;

    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        btn_up;
    logic        btn_down;
    logic        btn_start;
    logic [9:0]  paddle0_pos_y;
    logic [9:0]  ball_pos_x;
    logic [9:0]  ball_pos_y;
    logic [7:0]  score;
    logic [3:0]  miss_count;
    game_state_t game_state;

    modport master (
        output sx, sy, btn_up, btn_down, btn_start,
        input  paddle0_pos_y, ball_pos_x, ball_pos_y, score, miss_count, game_state
    );

    modport slave (
        input  sx, sy, btn_up, btn_down, btn_start,
        output paddle0_pos_y, ball_pos_x, ball_pos_y, score, miss_count, game_state
    );

endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen
// Produces a one-clk_pxl pulse per video frame, the cycle after the pixel
// counter reports (0, SCREEN_H), i.e. at the start of vertical blanking.
//   clk_pxl : pixel clock
//   reset   : asynchronous, active-high
//   sx, sy  : current pixel position
//   tick    : registered frame pulse
module frame_tick_gen #(
    parameter int SCREEN_H = 480
) (
    input  logic       clk_pxl,
    input  logic       reset,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    output logic       tick
);

    always_ff @(posedge clk_pxl or posedge reset) begin
        if (reset)
            tick <= 1'b0;
        else
            tick <= (sx == 10'd0) && (sy == 10'(SCREEN_H));
    end

endmodule

// File: rtl/pong_game_engine.sv
// pong_game_engine
// Single-player Pong game state. Once per frame tick it moves the paddle,
// advances/bounces the ball, detects misses and keeps score. All state is
// registered and changes only on tick, so the display never sees a change
// mid-frame.
//   clk_pxl : pixel clock
//   reset   : asynchronous, active-high
//   bus     : pong_game_engine_if.slave (timing, buttons in; positions,
//             score, miss_count, game_state out)
module pong_game_engine
    import pong_game_engine_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int MAX_MISSES   = DEF_MAX_MISSES,
    parameter int BALL_X0      = DEF_BALL_X0,
    parameter int BALL_Y0      = DEF_BALL_Y0,
    parameter int PADDLE_Y0    = DEF_PADDLE_Y0
) (
    input  logic               clk_pxl,
    input  logic               reset,
    pong_game_engine_if.slave  bus
);

    localparam pos_t SW  = pos_t'(SCREEN_W);
    localparam pos_t SH  = pos_t'(SCREEN_H);
    localparam pos_t BSZ = pos_t'(BALL_SIZE);
    localparam pos_t PW  = pos_t'(PADDLE_W);
    localparam pos_t PH  = pos_t'(PADDLE_H);
    localparam pos_t BS  = pos_t'(BALL_SPEED);
    localparam pos_t PS  = pos_t'(PADDLE_SPEED);
    localparam pos_t X0  = pos_t'(BALL_X0);
    localparam pos_t Y0  = pos_t'(BALL_Y0);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

    logic tick;

    frame_tick_gen #(.SCREEN_H(SCREEN_H)) u_frame_tick (
        .clk_pxl (clk_pxl),
        .reset   (reset),
        .sx      (bus.sx),
        .sy      (bus.sy),
        .tick    (tick)
    );

    // Registered game state; the position registers are the outputs.
    logic [9:0]  paddle_y;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        dx_right;
    logic        dy_down;
    game_state_t state;
    logic [7:0]  serve_cnt;
    logic [7:0]  score_q;
    logic [3:0]  miss_q;

    // Next-state values computed from the pre-tick state.
    pos_t        paddle_n;
    pos_t        ball_x_n;
    pos_t        ball_y_n;
    logic        dx_n;
    logic        dy_n;
    game_state_t state_n;
    logic [7:0]  cnt_n;
    logic [7:0]  score_n;
    logic [3:0]  miss_n;

    pos_t py;
    pos_t bx;
    pos_t by;
    pos_t up_y;
    pos_t down_y;
    logic hit;

    assign py     = to_pos(paddle_y);
    assign bx     = to_pos(ball_x);
    assign by     = to_pos(ball_y);
    assign up_y   = py - PS;
    assign down_y = py + PS;

    // Ball overlaps the paddle's vertical extent (pre-tick paddle position).
    assign hit = (by + BSZ > py) && (by < py + PH);

    always_comb begin
        paddle_n = py;
        ball_x_n = bx;
        ball_y_n = by;
        dx_n     = dx_right;
        dy_n     = dy_down;
        state_n  = state;
        cnt_n    = serve_cnt;
        score_n  = score_q;
        miss_n   = miss_q;

        // Paddle moves in every state; both buttons cancel out.
        if (bus.btn_up && !bus.btn_down)
            paddle_n = up_y[10] ? pos_t'(0) : up_y;
        else if (bus.btn_down && !bus.btn_up)
            paddle_n = (down_y > SH - PH) ? SH - PH : down_y;

        case (state)
            SERVE: begin
                ball_x_n = X0;
                ball_y_n = Y0;
                if (serve_cnt == SERVE_LAST) begin
                    cnt_n   = '0;
                    dx_n    = 1'b0;
                    state_n = PLAY;
                end else begin
                    cnt_n = serve_cnt + 8'd1;
                end
            end

            PLAY: begin
                // Vertical and horizontal axes are independent, so a corner
                // reflects on both in the same tick.
                if (dy_down) begin
                    if (by + BS >= SH - BSZ) begin
                        ball_y_n = SH - BSZ;
                        dy_n     = 1'b0;
                    end else begin
                        ball_y_n = by + BS;
                    end
                end else begin
                    if (by <= BS) begin
                        ball_y_n = '0;
                        dy_n     = 1'b1;
                    end else begin
                        ball_y_n = by - BS;
                    end
                end

                if (dx_right) begin
                    if (bx + BS >= SW - BSZ) begin
                        ball_x_n = SW - BSZ;
                        dx_n     = 1'b0;
                    end else begin
                        ball_x_n = bx + BS;
                    end
                end else if (bx >= PW && bx - BS < PW) begin
                    // This step would carry the ball across the paddle face.
                    if (hit) begin
                        ball_x_n = PW;
                        dx_n     = 1'b1;
                        score_n  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end else begin
                        ball_x_n = bx - BS;
                    end
                end else if (bx < PW && bx < BS) begin
                    ball_x_n = '0;
                    state_n  = MISS;
                end else begin
                    ball_x_n = bx - BS;
                end
            end

            MISS: begin
                miss_n   = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
                ball_x_n = X0;
                ball_y_n = Y0;
                dx_n     = 1'b0;
                if (miss_n == MISS_LIMIT) begin
                    state_n = OVER;
                end else begin
                    state_n = SERVE;
                    cnt_n   = '0;
                end
            end

            OVER: begin
                ball_x_n = X0;
                ball_y_n = Y0;
                if (bus.btn_start) begin
                    score_n = '0;
                    miss_n  = '0;
                    cnt_n   = '0;
                    state_n = SERVE;
                end
            end

            default: state_n = SERVE;
        endcase
    end

    always_ff @(posedge clk_pxl or posedge reset) begin
        if (reset) begin
            paddle_y  <= 10'(PADDLE_Y0);
            ball_x    <= 10'(BALL_X0);
            ball_y    <= 10'(BALL_Y0);
            dx_right  <= 1'b1;
            dy_down   <= 1'b1;
            state     <= SERVE;
            serve_cnt <= '0;
            score_q   <= '0;
            miss_q    <= '0;
        end else if (tick) begin
            paddle_y  <= to_pix(paddle_n);
            ball_x    <= to_pix(ball_x_n);
            ball_y    <= to_pix(ball_y_n);
            dx_right  <= dx_n;
            dy_down   <= dy_n;
            state     <= state_n;
            serve_cnt <= cnt_n;
            score_q   <= score_n;
            miss_q    <= miss_n;
        end
    end

    assign bus.paddle0_pos_y = paddle_y;
    assign bus.ball_pos_x    = ball_x;
    assign bus.ball_pos_y    = ball_y;
    assign bus.score         = score_q;
    assign bus.miss_count    = miss_q;
    assign bus.game_state    = state;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine
// Directed bench for pong_game_engine. Frame ticks are produced by driving
// sx/sy to (0, 480) for one cycle. The main instance plays a full game from
// reset; a second instance with a low serve position and low paddle exercises
// a paddle hit coinciding with a bottom-wall reflection.
module tb_pong_game_engine;
    import pong_game_engine_pkg::*;

    logic clk_pxl = 1'b0;
    logic reset;
    logic reset2;

    int checks = 0;
    int fails  = 0;

    always #5 clk_pxl = ~clk_pxl;

    pong_game_engine_if bus1();
    pong_game_engine_if bus2();

    assign bus2.sx        = bus1.sx;
    assign bus2.sy        = bus1.sy;
    assign bus2.btn_up    = bus1.btn_up;
    assign bus2.btn_down  = bus1.btn_down;
    assign bus2.btn_start = bus1.btn_start;

    pong_game_engine u_dut (
        .clk_pxl (clk_pxl),
        .reset   (reset),
        .bus     (bus1)
    );

    pong_game_engine #(
        .BALL_X0   (20),
        .BALL_Y0   (460),
        .PADDLE_Y0 (440)
    ) u_dut_corner (
        .clk_pxl (clk_pxl),
        .reset   (reset2),
        .bus     (bus2)
    );

    // One frame tick; returns at a falling edge with the tick applied.
    task automatic do_tick();
        @(negedge clk_pxl);
        bus1.sx = 10'd0;
        bus1.sy = 10'd480;
        @(negedge clk_pxl);
        bus1.sx = 10'd5;
        bus1.sy = 10'd0;
        @(negedge clk_pxl);
    endtask

    task automatic test_reset();
        bus1.sx = 10'd5;
        bus1.sy = 10'd0;
        bus1.btn_up = 1'b0;
        bus1.btn_down = 1'b0;
        bus1.btn_start = 1'b0;
        reset = 1'b1;
        reset2 = 1'b1;
        repeat (3) @(negedge clk_pxl);
        reset = 1'b0;
        @(negedge clk_pxl);
        checks++;
        if (bus1.paddle0_pos_y !== 10'd220) begin
            fails++;
            $display("FAIL reset_paddle got %0d exp 220", bus1.paddle0_pos_y);
        end
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd316, 10'd236}) begin
            fails++;
            $display("FAIL reset_ball got (%0d,%0d) exp (316,236)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
        checks++;
        if ({bus1.score, bus1.miss_count} !== {8'd0, 4'd0}) begin
            fails++;
            $display("FAIL reset_score got score %0d miss %0d exp 0 0", bus1.score, bus1.miss_count);
        end
        checks++;
        if (bus1.game_state !== SERVE) begin
            fails++;
            $display("FAIL reset_state got %0d exp 0", bus1.game_state);
        end
        // Near-miss timing positions and held buttons must not move anything.
        bus1.btn_down = 1'b1;
        bus1.sx = 10'd1;
        bus1.sy = 10'd480;
        repeat (4) @(negedge clk_pxl);
        bus1.sx = 10'd0;
        bus1.sy = 10'd479;
        repeat (4) @(negedge clk_pxl);
        bus1.sx = 10'd5;
        bus1.sy = 10'd0;
        bus1.btn_down = 1'b0;
        @(negedge clk_pxl);
        checks++;
        if (bus1.paddle0_pos_y !== 10'd220) begin
            fails++;
            $display("FAIL no_tick_hold got paddle %0d exp 220", bus1.paddle0_pos_y);
        end
    endtask

    task automatic test_serve();
        for (int t = 1; t <= 61; t++) begin
            do_tick();
            if (t <= 59) begin
                checks++;
                if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state} !== {10'd316, 10'd236, SERVE}) begin
                    fails++;
                    $display("FAIL serve_hold t=%0d got (%0d,%0d) st %0d exp (316,236) st 0",
                             t, bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state);
                end
            end else if (t == 60) begin
                checks++;
                if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state} !== {10'd316, 10'd236, PLAY}) begin
                    fails++;
                    $display("FAIL serve_launch got (%0d,%0d) st %0d exp (316,236) st 1",
                             bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state);
                end
            end else begin
                checks++;
                if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd314, 10'd238}) begin
                    fails++;
                    $display("FAIL first_move got (%0d,%0d) exp (314,238)", bus1.ball_pos_x, bus1.ball_pos_y);
                end
            end
        end
    endtask

    // Play ticks 2..74: paddle down to the floor, both held, then up 10 times.
    task automatic test_paddle();
        int exp_y;
        bus1.btn_down = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            do_tick();
            exp_y = (220 + 4 * k > 440) ? 440 : 220 + 4 * k;
            checks++;
            if (bus1.paddle0_pos_y !== 10'(exp_y)) begin
                fails++;
                $display("FAIL paddle_down k=%0d got %0d exp %0d", k, bus1.paddle0_pos_y, exp_y);
            end
        end
        bus1.btn_up = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            checks++;
            if (bus1.paddle0_pos_y !== 10'd440) begin
                fails++;
                $display("FAIL paddle_both k=%0d got %0d exp 440", k, bus1.paddle0_pos_y);
            end
        end
        bus1.btn_down = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            exp_y = 440 - 4 * k;
            checks++;
            if (bus1.paddle0_pos_y !== 10'(exp_y)) begin
                fails++;
                $display("FAIL paddle_up k=%0d got %0d exp %0d", k, bus1.paddle0_pos_y, exp_y);
            end
        end
        bus1.btn_up = 1'b0;
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd168, 10'd384}) begin
            fails++;
            $display("FAIL ball_n74 got (%0d,%0d) exp (168,384)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
    endtask

    // Ball reaches the paddle face at play tick 153 with y=402, paddle at 400.
    task automatic test_paddle_hit();
        repeat (79) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.score} !== {10'd10, 10'd402, 8'd0}) begin
            fails++;
            $display("FAIL pre_hit got (%0d,%0d) score %0d exp (10,402) score 0",
                     bus1.ball_pos_x, bus1.ball_pos_y, bus1.score);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.score, bus1.game_state} !== {10'd10, 10'd400, 8'd1, PLAY}) begin
            fails++;
            $display("FAIL hit got (%0d,%0d) score %0d st %0d exp (10,400) score 1 st 1",
                     bus1.ball_pos_x, bus1.ball_pos_y, bus1.score, bus1.game_state);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd12, 10'd398}) begin
            fails++;
            $display("FAIL post_hit got (%0d,%0d) exp (12,398)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
    endtask

    task automatic test_walls();
        repeat (198) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd408, 10'd2}) begin
            fails++;
            $display("FAIL near_top got (%0d,%0d) exp (408,2)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd410, 10'd0}) begin
            fails++;
            $display("FAIL top_wall got (%0d,%0d) exp (410,0)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd412, 10'd2}) begin
            fails++;
            $display("FAIL top_reflect got (%0d,%0d) exp (412,2)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
        repeat (109) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd630, 10'd220}) begin
            fails++;
            $display("FAIL near_right got (%0d,%0d) exp (630,220)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd632, 10'd222}) begin
            fails++;
            $display("FAIL right_wall got (%0d,%0d) exp (632,222)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd630, 10'd224}) begin
            fails++;
            $display("FAIL right_reflect got (%0d,%0d) exp (630,224)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
    endtask

    // Return trip arrives at x=10 with y=100 while the paddle sits at 400.
    task automatic test_miss();
        repeat (310) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd10, 10'd100}) begin
            fails++;
            $display("FAIL pre_miss got (%0d,%0d) exp (10,100)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
        for (int k = 1; k <= 5; k++) begin
            do_tick();
            checks++;
            if ({bus1.ball_pos_x, bus1.game_state} !== {10'(10 - 2 * k), PLAY}) begin
                fails++;
                $display("FAIL miss_slide k=%0d got x %0d st %0d exp x %0d st 1",
                         k, bus1.ball_pos_x, bus1.game_state, 10 - 2 * k);
            end
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.game_state, bus1.miss_count} !== {10'd0, MISS, 4'd0}) begin
            fails++;
            $display("FAIL miss_enter got x %0d st %0d miss %0d exp x 0 st 2 miss 0",
                     bus1.ball_pos_x, bus1.game_state, bus1.miss_count);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state, bus1.miss_count, bus1.score}
            !== {10'd316, 10'd236, SERVE, 4'd1, 8'd1}) begin
            fails++;
            $display("FAIL miss_count1 got (%0d,%0d) st %0d miss %0d score %0d exp (316,236) st 0 miss 1 score 1",
                     bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state, bus1.miss_count, bus1.score);
        end
    endtask

    task automatic test_game_over();
        bus1.btn_up = 1'b1;
        repeat (60) do_tick();
        bus1.btn_up = 1'b0;
        checks++;
        if ({bus1.paddle0_pos_y, bus1.game_state} !== {10'd160, PLAY}) begin
            fails++;
            $display("FAIL serve2 got paddle %0d st %0d exp 160 st 1", bus1.paddle0_pos_y, bus1.game_state);
        end
        repeat (159) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.game_state} !== {10'd0, MISS}) begin
            fails++;
            $display("FAIL miss2_enter got x %0d st %0d exp x 0 st 2", bus1.ball_pos_x, bus1.game_state);
        end
        do_tick();
        checks++;
        if ({bus1.game_state, bus1.miss_count} !== {SERVE, 4'd2}) begin
            fails++;
            $display("FAIL miss_count2 got st %0d miss %0d exp st 0 miss 2", bus1.game_state, bus1.miss_count);
        end
        repeat (220) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state, bus1.miss_count, bus1.score}
            !== {10'd316, 10'd236, OVER, 4'd3, 8'd1}) begin
            fails++;
            $display("FAIL game_over got (%0d,%0d) st %0d miss %0d score %0d exp (316,236) st 3 miss 3 score 1",
                     bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state, bus1.miss_count, bus1.score);
        end
        bus1.btn_down = 1'b1;
        repeat (2) do_tick();
        bus1.btn_down = 1'b0;
        checks++;
        if ({bus1.paddle0_pos_y, bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state}
            !== {10'd168, 10'd316, 10'd236, OVER}) begin
            fails++;
            $display("FAIL over_hold got paddle %0d (%0d,%0d) st %0d exp 168 (316,236) st 3",
                     bus1.paddle0_pos_y, bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state);
        end
        bus1.btn_start = 1'b1;
        do_tick();
        bus1.btn_start = 1'b0;
        checks++;
        if ({bus1.game_state, bus1.score, bus1.miss_count} !== {SERVE, 8'd0, 4'd0}) begin
            fails++;
            $display("FAIL restart got st %0d score %0d miss %0d exp st 0 score 0 miss 0",
                     bus1.game_state, bus1.score, bus1.miss_count);
        end
    endtask

    task automatic test_reset_mid_play();
        repeat (65) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state} !== {10'd306, 10'd226, PLAY}) begin
            fails++;
            $display("FAIL pre_reset got (%0d,%0d) st %0d exp (306,226) st 1",
                     bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus1.paddle0_pos_y, bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state}
            !== {10'd220, 10'd316, 10'd236, SERVE}) begin
            fails++;
            $display("FAIL async_reset got paddle %0d (%0d,%0d) st %0d exp 220 (316,236) st 0",
                     bus1.paddle0_pos_y, bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state);
        end
        @(negedge clk_pxl);
        reset = 1'b0;
        repeat (60) do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state} !== {10'd316, 10'd236, PLAY}) begin
            fails++;
            $display("FAIL reserve got (%0d,%0d) st %0d exp (316,236) st 1",
                     bus1.ball_pos_x, bus1.ball_pos_y, bus1.game_state);
        end
        do_tick();
        checks++;
        if ({bus1.ball_pos_x, bus1.ball_pos_y} !== {10'd314, 10'd238}) begin
            fails++;
            $display("FAIL reset_dir got (%0d,%0d) exp (314,238)", bus1.ball_pos_x, bus1.ball_pos_y);
        end
    endtask

    // Serve at (20,460): at x=10 the ball is at y=470 moving down, so the
    // paddle hit and the bottom-wall clamp land on the same tick.
    task automatic test_corner();
        reset2 = 1'b0;
        repeat (65) do_tick();
        checks++;
        if ({bus2.ball_pos_x, bus2.ball_pos_y, bus2.paddle0_pos_y} !== {10'd10, 10'd470, 10'd440}) begin
            fails++;
            $display("FAIL corner_pre got (%0d,%0d) paddle %0d exp (10,470) paddle 440",
                     bus2.ball_pos_x, bus2.ball_pos_y, bus2.paddle0_pos_y);
        end
        do_tick();
        checks++;
        if ({bus2.ball_pos_x, bus2.ball_pos_y, bus2.score} !== {10'd10, 10'd472, 8'd1}) begin
            fails++;
            $display("FAIL corner_hit got (%0d,%0d) score %0d exp (10,472) score 1",
                     bus2.ball_pos_x, bus2.ball_pos_y, bus2.score);
        end
        do_tick();
        checks++;
        if ({bus2.ball_pos_x, bus2.ball_pos_y} !== {10'd12, 10'd470}) begin
            fails++;
            $display("FAIL corner_post got (%0d,%0d) exp (12,470)", bus2.ball_pos_x, bus2.ball_pos_y);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle();
        test_paddle_hit();
        test_walls();
        test_miss();
        test_game_over();
        test_reset_mid_play();
        test_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
